// File: rtl/bus_arb4.sv
// ---------------------------------------------------------------------------
// bus_arb4 - four-requester round-robin bus arbiter with a registered shared
//            data path and a bounded ownership tenure.
//
// The arbiter grants the shared bus to one requester at a time. While the
// owner keeps its request high, one beat of its data is forwarded per cycle.
// When the owner drops its request, the bus is handed over in the same cycle,
// or the arbiter goes idle if nobody else is asking. When an owner has held
// the bus for MAX_BEATS consecutive beats, it is forced to give it up. The
// round-robin pointer then gives that owner lowest priority, so it keeps the
// bus with no gap only if nobody else is requesting.
//
// Parameters
//   WIDTH      data width of each requester port and of the shared output
//   MAX_BEATS  longest continuous tenure before forced rotation (2..256)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req[3:0]   request level, bit k belongs to requester k
//   I0..I3     requester data
//   gnt[3:0]   registered one-hot grant, zero when there is no owner
//   s[1:0]     registered owner index (shared 4:1 select); holds when idle
//   o          registered shared bus data; holds when no beat is transferred
//   valid      registered; high when o carries a beat from the owner
// ---------------------------------------------------------------------------
module bus_arb4 #(
  parameter int WIDTH     = 32,
  parameter int MAX_BEATS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  input  logic [WIDTH-1:0] I3,
  output logic [3:0]       gnt,
  output logic [1:0]       s,
  output logic [WIDTH-1:0] o,
  output logic             valid
);

  localparam int                CNT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(MAX_BEATS - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t             r_state;
  logic [3:0]         r_gnt;
  logic [1:0]         r_s;
  logic [WIDTH-1:0]   r_o;
  logic               r_valid;
  logic [1:0]         r_ptr;       // highest-priority requester for the next decision
  logic [CNT_W-1:0]   r_beat_cnt;  // beats already taken in the current tenure

  logic               w_win_any;
  logic [1:0]         w_win_off;
  logic [1:0]         w_win_idx;
  logic               w_own_req;
  logic               w_last_beat;
  logic [WIDTH-1:0]   w_own_data;

  // Round-robin search: walk ptr, ptr+1, ptr+2, ptr+3 (mod 4) and keep the
  // nearest asserted request. Scanning from the far end down means the
  // closest hit is the one left in w_win_off.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_win_any = 1'b0;
    w_win_off = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[r_ptr + 2'(i)]) begin
        w_win_any = 1'b1;
        w_win_off = 2'(i);
      end
    end
  end

  assign w_win_idx = r_ptr + w_win_off;  // 2-bit add wraps mod 4

  // Shared 4:1 data select, steered by the registered owner index.
  always_comb begin
    w_own_data = I0;
    case (r_s)
      2'd0:    w_own_data = I0;
      2'd1:    w_own_data = I1;
      2'd2:    w_own_data = I2;
      default: w_own_data = I3;
    endcase
  end

  assign w_own_req   = req[r_s];
  assign w_last_beat = (r_beat_cnt == LAST_BEAT);

  // Control FSM and every registered output live in one sequential block.
  // Each (re)grant loads the owner, moves ptr past the winner and clears the
  // beat counter. This also holds for a forced re-grant to the same owner.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values and the block order does not matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_gnt      <= 4'b0000;
      r_s        <= 2'd0;
      r_o        <= '0;
      r_valid    <= 1'b0;
      r_ptr      <= 2'd0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_valid <= 1'b0;
          if (w_win_any) begin
            r_state    <= ST_BUSY;
            r_gnt      <= 4'b0001 << w_win_idx;
            r_s        <= w_win_idx;
            r_ptr      <= w_win_idx + 2'd1;
            r_beat_cnt <= '0;
          end
        end

        ST_BUSY: begin
          if (w_own_req) begin
            // The owner still asks: this cycle transfers a beat.
            r_o     <= w_own_data;
            r_valid <= 1'b1;
            if (w_last_beat) begin
              // Tenure exhausted. The owner's own request guarantees a
              // winner, and ptr already points past the owner, so the owner
              // wins again only if nobody else is requesting.
              r_gnt      <= 4'b0001 << w_win_idx;
              r_s        <= w_win_idx;
              r_ptr      <= w_win_idx + 2'd1;
              r_beat_cnt <= '0;
            end else begin
              r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
          end else begin
            // Voluntary release: no beat, o keeps its last value.
            r_valid <= 1'b0;
            if (w_win_any) begin
              // Hand the bus straight to the next requester, with no idle bubble.
              r_gnt      <= 4'b0001 << w_win_idx;
              r_s        <= w_win_idx;
              r_ptr      <= w_win_idx + 2'd1;
              r_beat_cnt <= '0;
            end else begin
              // Nobody is waiting. s keeps the last owner index.
              r_state    <= ST_IDLE;
              r_gnt      <= 4'b0000;
              r_beat_cnt <= '0;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt   = r_gnt;
  assign s     = r_s;
  assign o     = r_o;
  assign valid = r_valid;

endmodule

// File: tb/tb_bus_arb4.sv
// ---------------------------------------------------------------------------
// tb_bus_arb4 - self-checking bench for bus_arb4 (WIDTH=32, MAX_BEATS=8).
// Directed scenarios are followed by randomized request patterns. Each cycle
// is compared against a behavioural model of the arbitration rules, and the
// grant, select and valid invariants are checked on every cycle.
// ---------------------------------------------------------------------------
module tb_bus_arb4;

  localparam int WIDTH = 32;
  localparam int MAXB  = 8;

  logic             clk;
  logic             rst_n;
  logic [3:0]       req;
  logic [WIDTH-1:0] I0, I1, I2, I3;
  logic [3:0]       gnt;
  logic [1:0]       s;
  logic [WIDTH-1:0] o;
  logic             valid;

  bus_arb4 #(.WIDTH(WIDTH), .MAX_BEATS(MAXB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .I0    (I0),
    .I1    (I1),
    .I2    (I2),
    .I3    (I3),
    .gnt   (gnt),
    .s     (s),
    .o     (o),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state. owner == -1 means no owner.
  int               m_owner;
  int               m_ptr;
  int               m_beats;
  logic [3:0]       m_gnt;
  logic [1:0]       m_s;
  logic [WIDTH-1:0] m_o;
  logic             m_valid;
  logic [3:0]       prev_gnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) begin
      if (r[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_beats = 0;
    m_gnt = 4'b0; m_s = 2'd0; m_o = '0; m_valid = 1'b0;
  endtask

  task automatic model_grant(input int w);
    m_owner = w;
    m_gnt   = 4'(1 << w);
    m_s     = 2'(w);
    m_ptr   = (w + 1) % 4;
    m_beats = 0;
  endtask

  task automatic model_edge(input logic [3:0] r, input logic [WIDTH-1:0] d0,
                            input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d2,
                            input logic [WIDTH-1:0] d3);
    logic [WIDTH-1:0] d [4];
    int w;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    if (m_owner < 0) begin
      m_valid = 1'b0;
      w = rr_pick(r, m_ptr);
      if (w >= 0) model_grant(w);
    end else if (r[m_owner]) begin
      m_o = d[m_owner];
      m_valid = 1'b1;
      m_beats++;
      if (m_beats == MAXB) model_grant(rr_pick(r, m_ptr));
    end else begin
      m_valid = 1'b0;
      w = rr_pick(r, m_ptr);
      if (w >= 0) model_grant(w);
      else begin
        m_owner = -1;
        m_gnt   = 4'b0;
      end
    end
  endtask

  task automatic drive(input logic [3:0] r);
    req = r;
    I0 = $urandom; I1 = $urandom; I2 = $urandom; I3 = $urandom;
  endtask

  // One clock: the model sees the same inputs the DUT sampled. Outputs are
  // compared 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    model_edge(req, I0, I1, I2, I3);
    #1;
    check("gnt", 64'(gnt), 64'(m_gnt));
    check("s", 64'(s), 64'(m_s));
    check("o", 64'(o), 64'(m_o));
    check("valid", 64'(valid), 64'(m_valid));
    check("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
    check("s_matches_gnt", 64'((gnt == 4'd0) || (gnt == (4'b0001 << s))), 64'd1);
    check("valid_needs_prev_gnt", 64'(!valid || (prev_gnt != 4'd0)), 64'd1);
    prev_gnt = gnt;
  endtask

  // Assert reset between edges, confirm that it clears the outputs at once,
  // then release it between edges and confirm that nothing is granted before
  // the next edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_gnt", 64'(gnt), 64'd0);
    check("rst_async_s", 64'(s), 64'd0);
    check("rst_async_o", 64'(o), 64'd0);
    check("rst_async_valid", 64'(valid), 64'd0);
    model_reset();
    prev_gnt = 4'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    check("rst_release_gnt", 64'(gnt), 64'd0);
  endtask

  initial begin
    logic [1:0]       own_prev;
    logic [WIDTH-1:0] last_i2;
    logic [3:0]       r;
    int               n;

    rst_n = 1'b1;
    req = 4'b0; I0 = '0; I1 = '0; I2 = '0; I3 = '0;
    prev_gnt = 4'b0;
    model_reset();

    // Single requester 1: grant latency and first-beat latency.
    do_reset();
    drive(4'b0010);
    tick();
    check("r029_gnt", 64'(gnt), 64'h2);
    check("r029_s", 64'(s), 64'd1);
    check("r029_valid0", 64'(valid), 64'd0);
    drive(4'b0010);
    I1 = 32'hA5A5_0001;
    tick();
    check("r029_valid", 64'(valid), 64'd1);
    check("r029_o", 64'(o), 64'hA5A5_0001);

    // All requesting: rotation 0,1,2,3,0 with 8 beats each and no gaps.
    do_reset();
    for (int t = 1; t <= 34; t++) begin
      drive(4'b1111);
      own_prev = s;
      tick();
      if (t >= 2) begin
        check("r030_valid", 64'(valid), 64'd1);
        check("r030_owner", 64'(own_prev), 64'(((t - 2) / MAXB) % 4));
      end
    end

    // Owner 2 releases while requester 0 waits: direct handover.
    do_reset();
    drive(4'b0100);
    tick();
    check("r031_gnt2", 64'(gnt), 64'h4);
    last_i2 = '0;
    repeat (3) begin
      drive(4'b0101);
      last_i2 = I2;
      tick();
    end
    drive(4'b0001);
    tick();
    check("r031_gnt", 64'(gnt), 64'h1);
    check("r031_valid", 64'(valid), 64'd0);
    check("r031_o_hold", 64'(o), 64'(last_i2));

    // Lone requester 3 for 20 beats: forced re-grants cause no bubble.
    do_reset();
    drive(4'b1000);
    tick();
    repeat (20) begin
      drive(4'b1000);
      tick();
      check("r032_valid", 64'(valid), 64'd1);
      check("r032_gnt", 64'(gnt), 64'h8);
    end

    // Reset during beat 4 of owner 1, then req=1010 from ptr=0.
    do_reset();
    drive(4'b0010);
    tick();
    repeat (4) begin
      drive(4'b0010);
      tick();
    end
    check("r033_pre_valid", 64'(valid), 64'd1);
    do_reset();
    drive(4'b1010);
    tick();
    check("r033_first_gnt", 64'(gnt), 64'h2);
    check("r033_first_s", 64'(s), 64'd1);

    // Randomized request patterns held for random lengths, with occasional resets.
    repeat (60) begin
      r = 4'($urandom_range(0, 15));
      n = $urandom_range(1, 14);
      repeat (n) begin
        if ($urandom_range(0, 7) == 0) r[$urandom_range(0, 3)] = ~r[$urandom_range(0, 3)];
        drive(r);
        tick();
      end
      if ($urandom_range(0, 9) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
